// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional statistics counters are enabled with DMEM_ARB_STATS_EN.
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB_CORE_PRI   = 1'b0,
    ARB_LOADER_PRI = 1'b1
  } arb_state_e;

  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned STAT_W      = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_rsp_reg.sv
// Per-port read response: captures RAM read data on a granted read and
// raises rvalid for the following cycle.
module dmem_rsp_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_capture,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata
);

  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_capture;
      if (i_capture) r_rdata <= i_rdata;
    end
  end

  // A response pending when reset arrives is hidden in the reset cycle itself.
  assign o_rvalid = r_rvalid & ~i_rst;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core / loader) arbiter for a single-port data RAM with loader
// anti-starvation. Define DMEM_ARB_STATS_EN to add grant/conflict counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_c_gnt,
  output logic [STAT_W-1:0] stat_l_gnt,
  output logic [STAT_W-1:0] stat_conflict
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  arb_state_e r_state;
  logic [3:0] r_wait_cnt;
  logic [3:0] w_wait_nxt;
  logic       w_c_gnt;
  logic       w_l_gnt;

  assign w_c_gnt = ~rst & c_req & (~l_req | (r_state == ARB_CORE_PRI));
  assign w_l_gnt = ~rst & l_req & (~c_req | (r_state == ARB_LOADER_PRI));
  assign c_gnt   = w_c_gnt;
  assign l_gnt   = w_l_gnt;

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (w_l_gnt)
      w_wait_nxt = '0;
    else if (l_req && (r_wait_cnt != WAIT_MAX))
      w_wait_nxt = r_wait_cnt + 4'd1;
  end

  // Loader priority is granted once the stall count saturates and is spent
  // on exactly one loader grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_CORE_PRI;
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      case (r_state)
        ARB_CORE_PRI:   if (w_wait_nxt == WAIT_MAX) r_state <= ARB_LOADER_PRI;
        ARB_LOADER_PRI: if (w_l_gnt) r_state <= ARB_CORE_PRI;
        default:        r_state <= ARB_CORE_PRI;
      endcase
    end
  end

  always_comb begin
    m_read  = 1'b0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (w_c_gnt) begin
      m_read  = ~c_we;
      m_write = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (w_l_gnt) begin
      m_read  = ~l_we;
      m_write = l_we;
      m_addr  = l_addr;
      m_wdata = l_wdata;
    end
  end

  dmem_rsp_reg #(.DATA_W(DATA_W)) u_c_rsp (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_capture (w_c_gnt & ~c_we),
    .i_rdata   (m_rdata),
    .o_rvalid  (c_rvalid),
    .o_rdata   (c_rdata)
  );

  dmem_rsp_reg #(.DATA_W(DATA_W)) u_l_rsp (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_capture (w_l_gnt & ~l_we),
    .i_rdata   (m_rdata),
    .o_rvalid  (l_rvalid),
    .o_rdata   (l_rdata)
  );

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_c;
  logic [STAT_W-1:0] r_stat_l;
  logic [STAT_W-1:0] r_stat_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_c <= '0;
      r_stat_l <= '0;
      r_stat_x <= '0;
    end else begin
      if (w_c_gnt) r_stat_c <= sat_inc(r_stat_c);
      if (w_l_gnt) r_stat_l <= sat_inc(r_stat_l);
      if (c_req && l_req) r_stat_x <= sat_inc(r_stat_x);
    end
  end

  assign stat_c_gnt    = r_stat_c;
  assign stat_l_gnt    = r_stat_l;
  assign stat_conflict = r_stat_x;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, checked against a stall-count reference model and a shadow memory.
module tb_dmem_arbiter;

  localparam int unsigned MW = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [31:0] c_rdata, l_rdata;
  logic        m_read, m_write;
  logic [31:0] m_addr, m_wdata, m_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_c_gnt, stat_l_gnt, stat_conflict;
`endif

  logic [31:0] ram [0:15] = '{5: 32'hDEADBEEF, default: 32'h0};
  logic [31:0] shadow [0:15];

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  int unsigned lstall;
  logic        exp_cg, exp_lg;
  logic        m_c_rv, m_l_rv;
  logic [31:0] m_c_rd, m_l_rd;
  logic        obs_cg, obs_lg, obs_mw, obs_crv, obs_lrv;
  logic [31:0] obs_crd;

  always #5 clk = ~clk;

  always @(posedge clk) if (m_write) ram[m_addr[3:0]] <= m_wdata;
  assign m_rdata = ram[m_addr[3:0]];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk      (clk),
    .rst      (rst),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .l_req    (l_req),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_gnt    (l_gnt),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata),
    .m_read   (m_read),
    .m_write  (m_write),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_c_gnt    (stat_c_gnt),
    .stat_l_gnt    (stat_l_gnt),
    .stat_conflict (stat_conflict)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: called just after a negedge with inputs already driven.
  task automatic cycle();
    #1;
    if (rst) begin
      exp_cg = 1'b0;
      exp_lg = 1'b0;
    end else begin
      exp_lg = l_req && (!c_req || lstall >= MW);
      exp_cg = c_req && !exp_lg;
    end
    obs_cg  = c_gnt;
    obs_lg  = l_gnt;
    obs_mw  = m_write;
    obs_crv = c_rvalid;
    obs_lrv = l_rvalid;
    obs_crd = c_rdata;
    chk("c_gnt", c_gnt, exp_cg);
    chk("l_gnt", l_gnt, exp_lg);
    chk("m_read", m_read, (exp_cg && !c_we) || (exp_lg && !l_we));
    chk("m_write", m_write, (exp_cg && c_we) || (exp_lg && l_we));
    chk("m_addr", m_addr, exp_cg ? c_addr : (exp_lg ? l_addr : 32'h0));
    chk("m_wdata", m_wdata, exp_cg ? c_wdata : (exp_lg ? l_wdata : 32'h0));
    chk("c_rvalid", c_rvalid, m_c_rv && !rst);
    chk("c_rdata", c_rdata, m_c_rd);
    chk("l_rvalid", l_rvalid, m_l_rv && !rst);
    chk("l_rdata", l_rdata, m_l_rd);
    @(posedge clk);
    if (rst) begin
      m_c_rv = 1'b0;
      m_l_rv = 1'b0;
      m_c_rd = '0;
      m_l_rd = '0;
      lstall = 0;
    end else begin
      m_c_rv = exp_cg && !c_we;
      m_l_rv = exp_lg && !l_we;
      if (m_c_rv) m_c_rd = shadow[c_addr[3:0]];
      if (m_l_rv) m_l_rd = shadow[l_addr[3:0]];
      if (exp_cg && c_we) shadow[c_addr[3:0]] = c_wdata;
      if (exp_lg && l_we) shadow[l_addr[3:0]] = l_wdata;
      if (exp_lg) lstall = 0;
      else if (l_req && lstall < MW) lstall++;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
    shadow[5] = 32'hDEADBEEF;
    m_c_rv = 1'b0; m_l_rv = 1'b0; m_c_rd = '0; m_l_rd = '0; lstall = 0;

    // Reset held 3 cycles with both requesting
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd1; c_wdata = 32'h0;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'd2; l_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_no_gnt", {31'h0, obs_cg | obs_lg}, 32'h0);
      chk("rst_rvalid", {31'h0, obs_crv | obs_lrv}, 32'h0);
    end
    rst = 1'b0;
    cycle();
    chk("post_rst_c_gnt", {31'h0, obs_cg}, 32'h1);

    // Core read of preloaded word
    l_req = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd5;
    cycle();
    chk("core_rd_gnt", {31'h0, obs_cg}, 32'h1);
    c_req = 1'b0;
    cycle();
    chk("core_rd_valid", {31'h0, obs_crv}, 32'h1);
    chk("core_rd_data", obs_crd, 32'hDEADBEEF);
    chk("core_rd_l_valid", {31'h0, obs_lrv}, 32'h0);

    // Loader write, then core reads it back
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'd7; l_wdata = 32'h12345678;
    cycle();
    chk("ld_wr_gnt", {31'h0, obs_lg}, 32'h1);
    chk("ld_wr_mwrite", {31'h0, obs_mw}, 32'h1);
    l_req = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd7;
    cycle();
    c_req = 1'b0;
    cycle();
    chk("wr_rd_valid", {31'h0, obs_crv}, 32'h1);
    chk("wr_rd_data", obs_crd, 32'h12345678);

    // Reset arriving the cycle after a granted read
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd5;
    cycle();
    c_req = 1'b0; rst = 1'b1;
    cycle();
    chk("rst_mid_rvalid", {31'h0, obs_crv}, 32'h0);
    rst = 1'b0;
    cycle();
    chk("rst_mid_after", {31'h0, obs_crv}, 32'h0);

    // Starvation: both held continuously straight out of reset
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd1;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'd2;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("starve_l_gnt", {31'h0, obs_lg}, {31'h0, (i % 4) == 3});
      chk("starve_c_gnt", {31'h0, obs_cg}, {31'h0, (i % 4) != 3});
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stat_c_gnt", {16'h0, stat_c_gnt}, 32'd6);
    chk("stat_l_gnt", {16'h0, stat_l_gnt}, 32'd2);
    chk("stat_conflict", {16'h0, stat_conflict}, 32'd8);
`endif
    c_req = 1'b0; l_req = 1'b0;
    cycle();

    // Random traffic; requests held until granted
    for (int n = 0; n < 400; n++) begin
      if (!c_req && ($urandom_range(0, 1) == 1)) begin
        c_req = 1'b1; c_we = 1'($urandom_range(0, 1));
        c_addr = $urandom_range(0, 15); c_wdata = $urandom;
      end
      if (!l_req && ($urandom_range(0, 1) == 1)) begin
        l_req = 1'b1; l_we = 1'($urandom_range(0, 1));
        l_addr = $urandom_range(0, 15); l_wdata = $urandom;
      end
      rst = ($urandom_range(0, 63) == 0);
      cycle();
      if (exp_cg || rst) c_req = 1'b0;
      if (exp_lg || rst) l_req = 1'b0;
    end
    rst = 1'b0; c_req = 1'b0; l_req = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
